// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants: icodes, status codes, instruction lengths,
// encoder FSM states and the byte-selection helper used by the encoder.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ERR = 2'd2;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_STOP = 2'd2
  } enc_state_e;

  // Byte idx of an encoded instruction; 9-byte forms have no register byte.
  function automatic logic [7:0] enc_byte(input logic [3:0] icode, input logic [3:0] ifun,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [63:0] valc, input logic [3:0] len,
                                          input logic [3:0] idx);
    logic [2:0] vidx;
    logic [7:0] b;
    vidx = 3'd0;
    if (idx == 4'd0) begin
      b = {icode, ifun};
    end else if (len == LEN_9) begin
      vidx = 3'(idx - 4'd1);
      b = valc[{vidx, 3'b000} +: 8];
    end else if (idx == 4'd1) begin
      b = {ra, rb};
    end else begin
      vidx = 3'(idx - 4'd2);
      b = valc[{vidx, 3'b000} +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/instr_len.sv
// Combinational icode/ifun decoder: reports whether the pair is a legal
// Y86-64 instruction and its encoded length in bytes.
module instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic       valid,
  output logic [3:0] length
);

  always_comb begin
    valid  = 1'b0;
    length = 4'd0;
    case (icode)
      I_HALT, I_NOP, I_RET: begin
        valid  = (ifun == 4'd0);
        length = LEN_1;
      end
      I_RRMOVQ: begin
        valid  = (ifun <= 4'd6);
        length = LEN_2;
      end
      I_OPQ: begin
        valid  = (ifun <= 4'd3);
        length = LEN_2;
      end
      I_PUSHQ, I_POPQ: begin
        valid  = (ifun == 4'd0);
        length = LEN_2;
      end
      I_JXX: begin
        valid  = (ifun <= 4'd6);
        length = LEN_9;
      end
      I_CALL: begin
        valid  = (ifun == 4'd0);
        length = LEN_9;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        valid  = (ifun == 4'd0);
        length = LEN_10;
      end
      default: begin
        valid  = 1'b0;
        length = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Y86-64 instruction encoder streaming one byte per cycle into instruction memory.
// Optional ENC_CHECKSUM_EN adds a running XOR checksum of all written bytes.
module instr_encoder
  import y86_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_ra,
  input  logic [3:0]        in_rb,
  input  logic [63:0]       in_valc,
  output logic              in_ready,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done,
`ifdef ENC_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic [1:0]        status
);

  enc_state_e state_q, state_d;
  // One extra bit so the pointer can sit exactly at MEM_DEPTH.
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [3:0]  len_q, len_d, idx_q, idx_d;
  logic [1:0]  status_q, status_d;

  logic       len_valid_s;
  logic [3:0] len_val_s;
  logic       fits_s;
  logic       last_s;

  instr_len u_instr_len (
    .icode  (in_icode),
    .ifun   (in_ifun),
    .valid  (len_valid_s),
    .length (len_val_s)
  );

  assign fits_s = ({28'd0, len_val_s} + 32'(ptr_q)) <= 32'(MEM_DEPTH);
  assign last_s = (idx_q == (len_q - 4'd1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    len_d    = len_q;
    idx_d    = idx_q;
    status_d = status_q;
    in_ready = (state_q == ST_IDLE) && (status_q == STAT_AOK) && !addr_load;
    case (state_q)
      ST_IDLE: begin
        if (addr_load) begin
          ptr_d = {1'b0, addr_in};
        end else if (in_valid && in_ready) begin
          if (!len_valid_s || !fits_s) begin
            status_d = STAT_ERR;
            state_d  = ST_STOP;
          end else begin
            icode_d = in_icode;
            ifun_d  = in_ifun;
            ra_d    = in_ra;
            rb_d    = in_rb;
            valc_d  = in_valc;
            len_d   = len_val_s;
            idx_d   = 4'd0;
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        ptr_d = ptr_q + (ADDR_W+1)'(1);
        if (last_s) begin
          if (icode_q == I_HALT) begin
            status_d = STAT_HLT;
            state_d  = ST_STOP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_STOP: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory port and status decode straight from the state flops.
  always_comb begin
    wr_en   = (state_q == ST_EMIT);
    wr_addr = '0;
    wr_data = 8'h00;
    done    = 1'b0;
    status  = status_q;
    if (wr_en) begin
      wr_addr = ptr_q[ADDR_W-1:0];
      wr_data = enc_byte(icode_q, ifun_q, ra_q, rb_q, valc_q, len_q, idx_q);
      done    = last_s;
      status  = (last_s && (icode_q == I_HALT)) ? STAT_HLT : status_q;
    end else begin
      status  = status_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      icode_q  <= 4'd0;
      ifun_q   <= 4'd0;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      valc_q   <= 64'd0;
      len_q    <= 4'd0;
      idx_q    <= 4'd0;
      status_q <= STAT_AOK;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      valc_q   <= valc_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      status_q <= status_d;
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    if (wr_en) begin
      csum_d = csum_q ^ wr_data;
    end else begin
      csum_d = csum_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus random
// instructions compared against a byte-list reference model.
module tb_instr_encoder;
  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] in_icode = 4'd0, in_ifun = 4'd0, in_ra = 4'd0, in_rb = 4'd0;
  logic [63:0] in_valc = 64'd0;
  logic in_ready;
  logic addr_load = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic done;
  logic [1:0] status;
`ifdef ENC_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  logic [7:0] csum_m = 8'h00;

  always #5 clock = ~clock;

  instr_encoder #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_icode  (in_icode),
    .in_ifun   (in_ifun),
    .in_ra     (in_ra),
    .in_rb     (in_rb),
    .in_valc   (in_valc),
    .in_ready  (in_ready),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
`ifdef ENC_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .status    (status)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction length from the ISA table; 0 means illegal.
  function automatic int ref_len(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h0, 4'h1, 4'h9: return (fn == 4'd0) ? 1 : 0;
      4'h2, 4'h7:       return (fn <= 4'd6) ? ((ic == 4'h2) ? 2 : 9) : 0;
      4'h6:             return (fn <= 4'd3) ? 2 : 0;
      4'hA, 4'hB:       return (fn == 4'd0) ? 2 : 0;
      4'h8:             return (fn == 4'd0) ? 9 : 0;
      4'h3, 4'h4, 4'h5: return (fn == 4'd0) ? 10 : 0;
      default:          return 0;
    endcase
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    in_valid = 1'b0;
    addr_load = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    ptr_m = 0;
    csum_m = 8'h00;
  endtask

  task automatic load_ptr(input int a, input bit with_valid);
    addr_load = 1'b1;
    addr_in = a[ADDR_W-1:0];
    in_valid = with_valid;
    in_icode = 4'h1;
    in_ifun = 4'h0;
    #1;
    chk("load_blocks_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    addr_load = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("load_no_write", {63'd0, wr_en}, 64'd0);
    chk("load_ready_after", {63'd0, in_ready}, 64'd1);
    ptr_m = a;
  endtask

  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] vc);
    logic [7:0] exp_q[$];
    int len;
    int waited;
    bit err;
    len = ref_len(ic, fn);
    exp_q = {};
    exp_q.push_back({ic, fn});
    if (len == 2 || len == 10) exp_q.push_back({ra, rb});
    if (len >= 9) for (int j = 0; j < 8; j++) exp_q.push_back(vc[8*j +: 8]);
    err = (len == 0) || (ptr_m + len > MEM_DEPTH);
    waited = 0;
    while (!in_ready && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    chk("ready_before_issue", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_icode = ic;
    in_ifun = fn;
    in_ra = ra;
    in_rb = rb;
    in_valc = vc;
    @(negedge clock);
    in_valid = 1'b0;
    if (err) begin
      repeat (3) begin
        chk("err_no_write", {63'd0, wr_en}, 64'd0);
        chk("err_status", {62'd0, status}, 64'd2);
        chk("err_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clock);
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        chk("wr_en", {63'd0, wr_en}, 64'd1);
        chk("wr_addr", 64'(wr_addr), 64'(ptr_m + i));
        chk("wr_data", 64'(wr_data), 64'(exp_q[i]));
        chk("done", {63'd0, done}, (i == len - 1) ? 64'd1 : 64'd0);
        chk("ready_in_emit", {63'd0, in_ready}, 64'd0);
        chk("status_emit", {62'd0, status}, (ic == 4'h0 && i == len - 1) ? 64'd1 : 64'd0);
        csum_m = csum_m ^ exp_q[i];
        @(negedge clock);
`ifdef ENC_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(csum_m));
`endif
      end
      chk("idle_wr_en", {63'd0, wr_en}, 64'd0);
      chk("idle_addr", 64'(wr_addr), 64'd0);
      chk("idle_data", 64'(wr_data), 64'd0);
      chk("idle_done", {63'd0, done}, 64'd0);
      chk("ready_after", {63'd0, in_ready}, (ic == 4'h0) ? 64'd0 : 64'd1);
      chk("status_after", {62'd0, status}, (ic == 4'h0) ? 64'd1 : 64'd0);
      ptr_m = ptr_m + len;
    end
  endtask

  initial begin
    logic [3:0] ric, rfn;
    reset_dut();
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_status", {62'd0, status}, 64'd0);
`ifdef ENC_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'd0);
`endif

    // irmovq, then call at a loaded origin, then back-to-back nop/addq
    run_instr(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    load_ptr(32'h100, 1'b1);
    run_instr(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
    reset_dut();
    run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    run_instr(4'h6, 4'h0, 4'h0, 4'h3, 64'd0);
    run_instr(4'h7, 4'h3, 4'h0, 4'h0, 64'hFEDC_BA98_7654_3210);

    // illegal function code is sticky
    run_instr(4'h6, 4'h7, 4'h0, 4'h0, 64'd0);
    in_valid = 1'b1;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    chk("err_sticky_status", {62'd0, status}, 64'd2);
    chk("err_sticky_ready", {63'd0, in_ready}, 64'd0);

    // memory-end boundary
    reset_dut();
    load_ptr(1020, 1'b0);
    run_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'h55);
    reset_dut();
    load_ptr(1014, 1'b0);
    run_instr(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    run_instr(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);

    // halt, then further requests are ignored
    reset_dut();
    run_instr(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    in_valid = 1'b1;
    in_icode = 4'h1;
    repeat (3) begin
      @(negedge clock);
      chk("halt_ignore_wr", {63'd0, wr_en}, 64'd0);
      chk("halt_ignore_status", {62'd0, status}, 64'd1);
      chk("halt_ignore_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;

    // reset in the middle of an instruction
    reset_dut();
    in_valid = 1'b1;
    in_icode = 4'h3;
    in_ifun = 4'h0;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_wr_en", {63'd0, wr_en}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready", {63'd0, in_ready}, 64'd1);
    ptr_m = 0;
    csum_m = 8'h00;

    // random legal and illegal instructions, with occasional origin reloads
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) load_ptr(int'($urandom_range(0, 1023)), $urandom_range(0, 1) == 1);
      ric = 4'($urandom_range(1, 11));
      rfn = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) :
            (ric == 4'h2 || ric == 4'h7) ? 4'($urandom_range(0, 6)) :
            (ric == 4'h6) ? 4'($urandom_range(0, 3)) : 4'd0;
      run_instr(ric, rfn, 4'($urandom), 4'($urandom), {$urandom, $urandom});
      if (status != 2'd0) reset_dut();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
